// File: rtl/alu_iterative_if.sv
// Handshake and operand/result bundle for the iterative execute unit.
// The producer side (operand muxes / controller) uses master; the ALU uses slave.
interface alu_iterative_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            Operation;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  illegal;
  logic                  busy;

  modport master (
    output in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, illegal, busy
  );

  modport slave (
    input  in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, illegal, busy
  );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith/compare/branch ops, plus a
// 1-bit-per-cycle shifter so no barrel shifter sits on the datapath.
module alu_iterative #(
  parameter int DATA_WIDTH = 32  // only 32 is supported
) (
  input  logic         clk,
  input  logic         reset,
  alu_iterative_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_BGE  = 4'b1010;
  localparam logic [3:0] OP_BLT  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_ADDI = 4'b1101;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SK_SLL = 2'd0, SK_SRL = 2'd1, SK_SRA = 2'd2} shift_kind_t;

  state_t                state, state_nxt;
  shift_kind_t           kind, kind_in;
  logic [DATA_WIDTH-1:0] acc, acc_sh, result, comb_res;
  logic [4:0]            cnt, shamt;
  logic                  illegal_q, is_shift, is_illegal, accept, cond;

  assign shamt      = bus.SrcB[4:0];
  assign is_shift   = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                      (bus.Operation == OP_SRA);
  assign is_illegal = (bus.Operation[3:1] == 3'b111);
  assign accept     = bus.in_valid && (state == IDLE);

  always_comb begin
    kind_in = SK_SLL;
    case (bus.Operation)
      OP_SRL:  kind_in = SK_SRL;
      OP_SRA:  kind_in = SK_SRA;
      default: kind_in = SK_SLL;
    endcase
  end

  // Single-cycle result; branch and SLT ops produce a zero-extended flag.
  always_comb begin
    cond     = 1'b0;
    comb_res = '0;
    case (bus.Operation)
      OP_AND:          comb_res = bus.SrcA & bus.SrcB;
      OP_OR:           comb_res = bus.SrcA | bus.SrcB;
      OP_XOR:          comb_res = bus.SrcA ^ bus.SrcB;
      OP_ADD, OP_ADDI: comb_res = bus.SrcA + bus.SrcB;
      OP_SUB:          comb_res = bus.SrcA - bus.SrcB;
      OP_BEQ: begin
        cond     = (bus.SrcA == bus.SrcB);
        comb_res = {{(DATA_WIDTH-1){1'b0}}, cond};
      end
      OP_BNE: begin
        cond     = (bus.SrcA != bus.SrcB);
        comb_res = {{(DATA_WIDTH-1){1'b0}}, cond};
      end
      OP_BGE: begin
        cond     = ($signed(bus.SrcA) >= $signed(bus.SrcB));
        comb_res = {{(DATA_WIDTH-1){1'b0}}, cond};
      end
      OP_BLT, OP_SLT: begin
        cond     = ($signed(bus.SrcA) < $signed(bus.SrcB));
        comb_res = {{(DATA_WIDTH-1){1'b0}}, cond};
      end
      default:         comb_res = '0;
    endcase
  end

  always_comb begin
    acc_sh = acc;
    case (kind)
      SK_SLL:  acc_sh = {acc[DATA_WIDTH-2:0], 1'b0};
      SK_SRL:  acc_sh = {1'b0, acc[DATA_WIDTH-1:1]};
      SK_SRA:  acc_sh = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
      default: acc_sh = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_nxt = (is_shift && shamt != 5'd0) ? SHIFT : DONE;
      end
      SHIFT: begin
        bus.busy = 1'b1;
        if (cnt == 5'd1) state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result/illegal only change on accept or shift completion, so they hold in DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc       <= '0;
      cnt       <= '0;
      kind      <= SK_SLL;
      result    <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (is_shift && shamt != 5'd0) begin
            acc       <= bus.SrcA;
            cnt       <= shamt;
            kind      <= kind_in;
            illegal_q <= 1'b0;
          end else begin
            result    <= is_shift ? bus.SrcA : comb_res;
            illegal_q <= is_illegal;
          end
        end
        SHIFT: begin
          acc <= acc_sh;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) result <= acc_sh;
        end
        default: ;
      endcase
    end
  end

  assign bus.ALUResult = result;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed + random checks of alu_iterative against a plain-arithmetic reference.
module tb_alu_iterative;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_iterative_if #(.DATA_WIDTH(32)) bus ();

  alu_iterative #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: result, illegal flag and cycles from accept to out_valid.
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = 32'h0;
    ill = 1'b0;
    lat = 1;
    case (op)
      4'd0:        r = a & b;
      4'd1:        r = a | b;
      4'd2, 4'd13: r = a + b;
      4'd3:        r = a ^ b;
      4'd6:        r = a - b;
      4'd4:        r = a << sh;
      4'd5:        r = a >> sh;
      4'd7:        r = 32'($signed(a) >>> sh);
      4'd8:        r = (a == b) ? 32'd1 : 32'd0;
      4'd9:        r = (a != b) ? 32'd1 : 32'd0;
      4'd10:       r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd11, 4'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:     ill = 1'b1;
    endcase
    if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && sh != 0) lat = 1 + sh;
  endtask

  // Entered #1 after a rising edge with the DUT idle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [31:0] er;
    logic        ei;
    int          el, cyc;
    ref_model(op, a, b, er, ei, el);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    @(posedge clk); #1;
    bus.Operation = 4'($urandom);
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
    bus.in_valid  = 1'($urandom);
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      chk("busy_shift", 32'(bus.busy), 32'd1);
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("latency", 32'(cyc), 32'(el));
    chk("busy_done", 32'(bus.busy), 32'd1);
    chk("result", bus.ALUResult, er);
    chk("illegal", 32'(bus.illegal), 32'(ei));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result", bus.ALUResult, er);
      chk("hold_illegal", 32'(bus.illegal), 32'(ei));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.Operation = 4'd0;
    bus.SrcA      = 32'h0;
    bus.SrcB      = 32'h0;

    // Power-on reset with junk on the inputs.
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.Operation = 4'b0100;
    bus.SrcB = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.ALUResult, 32'h0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 0);   // ADD wrap -> 1
    do_op(4'b0111, 32'h8000_0000, 32'h0000_001F, 0);   // SRA by 31
    do_op(4'b0101, 32'h8000_0000, 32'hFFFF_FFE4, 0);   // SRL, upper SrcB ignored
    do_op(4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 0);   // BLT -1 < 1
    do_op(4'b1010, 32'hFFFF_FFFF, 32'h0000_0001, 0);   // BGE
    do_op(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 0);   // illegal
    do_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);   // illegal
    do_op(4'b0110, 32'h0000_0000, 32'h0000_0001, 0);   // SUB wrap
    do_op(4'b0100, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0);   // SLL shamt 0
    do_op(4'b1100, 32'h8000_0000, 32'h7FFF_FFFF, 0);   // SLT signed
    do_op(4'b0010, 32'hCAFE_0000, 32'h0000_BABE, 10);  // backpressure

    // Reset while shifting with cnt = 7 (shamt 20, 13 shift cycles elapsed).
    bus.in_valid  = 1'b1;
    bus.Operation = 4'b0100;
    bus.SrcA      = 32'h0000_0001;
    bus.SrcB      = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (13) begin @(posedge clk); #1; end
    chk("midop_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", bus.ALUResult, 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_illegal", 32'(bus.illegal), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrel_in_ready", 32'(bus.in_ready), 32'd1);
    do_op(4'b0100, 32'h0000_0001, 32'h0000_0003, 0);   // fresh SLL -> 8

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (k % 4 == 0) a = {$urandom_range(1) == 1 ? 1'b1 : 1'b0, a[30:0]};
      if (k % 5 == 0) b = a;
      do_op(op, a, b, int'($urandom_range(2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
